puf_challenge_driver: RTL and testbench

Initiator side of the serial PUF challenge/response handshake.
- Sweeps an 8-bit challenge range. For each challenge it drives the challenge and enables, waits for the PUF's done, captures the response, and returns the acknowledge that clears the PUF.
- Hands each challenge/response pair to a downstream valid/ready sink, e.g. a UART packer.
- Lives on the same FPGA as the PUF, or on a companion board wired to the PUF's challenge, response, done and ack pins.

---
 rtl/puf_challenge_driver.sv | 196 +++++++++++++++++++
 tb/tb_puf_challenge_driver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_driver.sv
// rtl/puf_challenge_driver.sv - PUF challenge sweep initiator; define PUF_DONE_SYNC_EN to synchronize puf_done/puf_response
module puf_challenge_driver #(
  parameter int CHAL_W         = 8,
  parameter int RESP_W         = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal_first,
  input  logic [CHAL_W-1:0] chal_last,
  output logic [CHAL_W-1:0] challenge,
  output logic              enable,
  input  logic              puf_done,
  input  logic [RESP_W-1:0] puf_response,
  output logic              ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAL_W-1:0] out_chal,
  output logic [RESP_W-1:0] out_resp,
  output logic              out_err,
  output logic              busy,
  output logic              sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_CAPTURE,
    S_ACK,
    S_OUTPUT
  } state_e;

  // One shared 20-bit counter covers both the settle delay and the RUN timeout.
  localparam logic [19:0] SETTLE_LAST  = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CHAL_W-1:0] cur_q, cur_d;
  logic [CHAL_W-1:0] end_q, end_d;
  logic [19:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [CHAL_W-1:0] out_chal_q, out_chal_d;
  logic [RESP_W-1:0] out_resp_q, out_resp_d;
  logic              out_err_q, out_err_d;
  logic              sweep_done_q, sweep_done_d;

  // PUF-side inputs as seen by the FSM
  logic              done_s;
  logic [RESP_W-1:0] resp_s;

`ifdef PUF_DONE_SYNC_EN
  logic [1:0]        done_sync_q, done_sync_d;
  logic [RESP_W-1:0] resp_sync1_q, resp_sync1_d;
  logic [RESP_W-1:0] resp_sync2_q, resp_sync2_d;

  // Two-stage shift of the asynchronous PUF done and response
  always_comb begin
    done_sync_d  = {done_sync_q[0], puf_done};
    resp_sync1_d = puf_response;
    resp_sync2_d = resp_sync1_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (reset) begin
      done_sync_q  <= '0;
      resp_sync1_q <= '0;
      resp_sync2_q <= '0;
    end else begin
      done_sync_q  <= done_sync_d;
      resp_sync1_q <= resp_sync1_d;
      resp_sync2_q <= resp_sync2_d;
    end
  end

  assign done_s = done_sync_q[1];
  assign resp_s = resp_sync2_q;
`else
  assign done_s = puf_done;
  assign resp_s = puf_response;
`endif

  // Next-state logic for the per-challenge handshake and sweep bookkeeping
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    out_chal_d   = out_chal_q;
    out_resp_d   = out_resp_q;
    out_err_d    = out_err_q;
    sweep_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = chal_first;
          end_d   = chal_last;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_RUN: begin
        // done takes priority over a timeout landing in the same cycle
        if (done_s) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_CAPTURE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_CAPTURE: begin
        out_chal_d = cur_q;
        out_resp_d = err_q ? '0 : resp_s;
        out_err_d  = err_q;
        state_d    = S_ACK;
      end
      S_ACK: begin
        // A timed-out PUF may never raise done, so the ack is a single pulse then
        if (err_q || !done_s) begin
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (cur_q == end_q) begin
            sweep_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cur_d   = cur_q + CHAL_W'(1);
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      end_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      out_chal_q   <= '0;
      out_resp_q   <= '0;
      out_err_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      out_chal_q   <= out_chal_d;
      out_resp_q   <= out_resp_d;
      out_err_q    <= out_err_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Moore outputs decoded from the state; enable and ack live in disjoint states
  assign challenge  = cur_q;
  assign enable     = (state_q == S_RUN);
  assign ack        = (state_q == S_ACK);
  assign out_valid  = (state_q == S_OUTPUT);
  assign busy       = (state_q != S_IDLE);
  assign out_chal   = out_chal_q;
  assign out_resp   = out_resp_q;
  assign out_err    = out_err_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// tb/tb_puf_challenge_driver.sv - randomized self-checking bench for puf_challenge_driver
module tb_puf_challenge_driver;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;
  localparam int NEVER   = 100000;
`ifdef PUF_DONE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] chal_first;
  logic [7:0] chal_last;
  logic [7:0] challenge;
  logic       enable;
  logic       puf_done;
  logic [7:0] puf_response;
  logic       ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_chal;
  logic [7:0] out_resp;
  logic       out_err;
  logic       busy;
  logic       sweep_done;

  puf_challenge_driver #(
    .CHAL_W(8), .RESP_W(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .chal_first(chal_first), .chal_last(chal_last),
    .challenge(challenge), .enable(enable), .puf_done(puf_done), .puf_response(puf_response),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready), .out_chal(out_chal),
    .out_resp(out_resp), .out_err(out_err), .busy(busy), .sweep_done(sweep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] chal;
    logic [7:0] resp;
    logic       err;
    int         en_len;
    int         ack_len;
    logic       last;
  } pair_t;

  pair_t exp_q[$];

  // Per-challenge PUF behaviour: done delay after enable, ack cycles before release, response
  int         d_tbl[256];
  int         rel_tbl[256];
  logic [7:0] r_tbl[256];

  int n_tests = 0;
  int n_fail  = 0;
  int hold    = 0;
  bit rand_ready = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected pair list for a sweep, derived from the PUF behaviour tables
  task automatic push_sweep(input logic [7:0] f, input logic [7:0] l);
    logic [7:0] span;
    pair_t      p;
    span = l - f;
    for (int i = 0; i <= int'(span); i++) begin
      p.chal    = f + 8'(i);
      p.err     = (d_tbl[p.chal] + SYNC_LAT >= TIMEOUT);
      p.resp    = p.err ? 8'h00 : r_tbl[p.chal];
      p.en_len  = p.err ? TIMEOUT : d_tbl[p.chal] + 1 + SYNC_LAT;
      p.ack_len = p.err ? 1 : rel_tbl[p.chal] + 1 + SYNC_LAT;
      p.last    = (i == int'(span));
      exp_q.push_back(p);
    end
  endtask

  // PUF model, sink and protocol monitor, all sampled 1 time unit after the edge
  int run_idx = 0, ack_idx = 0, en_run = 0, ack_run = 0, last_en = 0, last_ack = 0;
  bit sd_expect = 0, prev_stall = 0;

  initial begin
    puf_done = 1'b0;
    puf_response = 8'h00;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        puf_done = 1'b0; out_ready = 1'b0;
        run_idx = 0; ack_idx = 0; en_run = 0; ack_run = 0; last_en = 0; last_ack = 0;
        sd_expect = 0; prev_stall = 0;
        continue;
      end
      if (sweep_done || sd_expect) chk("sweep_done_pulse", sweep_done, sd_expect);
      sd_expect = 0;
      if (enable || ack) chk("enable_ack_exclusive", enable && ack, 0);

      if (enable) begin
        en_run++;
        if (exp_q.size() > 0) chk("challenge_during_enable", challenge, exp_q[0].chal);
        if (run_idx == d_tbl[challenge]) begin
          puf_done = 1'b1;
          puf_response = r_tbl[challenge];
        end
        run_idx++;
      end else begin
        if (en_run > 0) last_en = en_run;
        en_run = 0;
        run_idx = 0;
      end

      if (ack) begin
        ack_run++;
        if (puf_done && ack_idx == rel_tbl[challenge]) puf_done = 1'b0;
        ack_idx++;
      end else begin
        if (ack_run > 0) last_ack = ack_run;
        ack_run = 0;
        ack_idx = 0;
      end
      if (!puf_done) puf_response = 8'($urandom);

      if (prev_stall) chk("valid_held_while_stalled", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("pair_unexpected", out_valid, 0);
          out_ready = 1'b1;
          prev_stall = 0;
        end else begin
          chk("out_chal", out_chal, exp_q[0].chal);
          chk("out_resp", out_resp, exp_q[0].resp);
          chk("out_err", out_err, exp_q[0].err);
          chk("challenge_in_output", challenge, exp_q[0].chal);
          chk("enable_in_output", enable, 0);
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (out_ready) begin
            chk("enable_cycles", last_en, exp_q[0].en_len);
            chk("ack_cycles", last_ack, exp_q[0].ack_len);
            sd_expect = exp_q[0].last;
            void'(exp_q.pop_front());
            prev_stall = 0;
          end else begin
            prev_stall = 1;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        prev_stall = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_enable", enable, 0);
    chk("rst_ack", ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    reset = 1'b0;
    exp_q.delete();
    hold = 0;
  endtask

  // Launch a sweep, poke an ignored start mid-sweep, wait (bounded) for completion
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, output int lat);
    int budget;
    push_sweep(f, l);
    budget = exp_q.size() * (TIMEOUT + 200) + hold + 100;
    chal_first = f; chal_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; chal_first = 8'($urandom); chal_last = 8'($urandom);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      if (lat < 0 && out_valid) lat = k - 1;
      if (sweep_done) break;
      if (k == 10 && busy) begin
        start = 1'b1; chal_first = 8'($urandom); chal_last = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("sweep_done_seen", sweep_done, 1);
    if (!sweep_done) do_reset();
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("busy_after_sweep", busy, 0);
  endtask

  int lat;
  int sd_cnt;
  logic [7:0] f;

  initial begin
    reset = 1'b1; start = 1'b0; chal_first = 8'h00; chal_last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d_tbl[i] = 5; rel_tbl[i] = 0; r_tbl[i] = 8'(i * 7 + 3);
    end
    repeat (2) @(negedge clk);
    chk("reset_challenge", challenge, 0);
    chk("reset_enable", enable, 0);
    chk("reset_ack", ack, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_chal", out_chal, 0);
    chk("reset_out_resp", out_resp, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sweep_done", sweep_done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single pair, done 20 cycles after enable, response 0xA5
    d_tbl[8'h10] = 20; r_tbl[8'h10] = 8'hA5; rel_tbl[8'h10] = 2;
    run_sweep(8'h10, 8'h10, lat);

    // Minimum latency: done already high in the first RUN cycle, released one cycle after ack
    d_tbl[8'h33] = 0; rel_tbl[8'h33] = 1;
    run_sweep(8'h33, 8'h33, lat);
    chk("min_latency", lat, SETTLE + 4 + 2 * SYNC_LAT);

    // Wrap-around sweep
    d_tbl[8'hFE] = 3; d_tbl[8'hFF] = 7; d_tbl[8'h00] = 1; d_tbl[8'h01] = 12;
    run_sweep(8'hFE, 8'h01, lat);

    // Timeout in the middle of a sweep; sweep continues
    d_tbl[8'h40] = NEVER;
    run_sweep(8'h3F, 8'h41, lat);

    // done lands on the final timeout count
    d_tbl[8'h50] = TIMEOUT - 1 - SYNC_LAT; r_tbl[8'h50] = 8'h3C;
    run_sweep(8'h50, 8'h50, lat);

    // Sink stalls 50 cycles
    hold = 50;
    run_sweep(8'h60, 8'h61, lat);

    // Reset mid-RUN of a 3-challenge sweep
    d_tbl[8'h70] = 30; d_tbl[8'h71] = 30; d_tbl[8'h72] = 30;
    push_sweep(8'h70, 8'h72);
    chal_first = 8'h70; chal_last = 8'h72; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !enable; k++) @(negedge clk);
    chk("reached_run", enable, 1);
    repeat (5) @(negedge clk);
    do_reset();
    sd_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sweep_done) sd_cnt++;
    end
    chk("no_sweep_done_after_reset", sd_cnt, 0);
    run_sweep(8'h70, 8'h72, lat);

    // Randomized sweeps with a random-ready sink
    rand_ready = 1;
    for (int s = 0; s < 15; s++) begin
      f = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
        case ($urandom_range(0, 9))
          0:       d_tbl[8'(f + 8'(i))] = NEVER;
          1:       d_tbl[8'(f + 8'(i))] = TIMEOUT - 1 - SYNC_LAT;
          default: d_tbl[8'(f + 8'(i))] = int'($urandom_range(0, 30));
        endcase
        rel_tbl[8'(f + 8'(i))] = int'($urandom_range(0, 3));
        r_tbl[8'(f + 8'(i))]   = 8'($urandom);
      end
      run_sweep(f, 8'(f + 8'($urandom_range(0, 5))), lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
